// File: rtl/gb_pkg.sv
// Shared Game Boy definitions.
//   - Interrupt source indices (bit position in IF/IE, 0 = highest priority)
//   - Default interrupt vector base and spacing
//   - Interrupt controller FSM state encoding
package gb_pkg;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_LCDC   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [7:0] VECTOR_BASE_DEF   = 8'h40;
  localparam logic [7:0] VECTOR_STRIDE_DEF = 8'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/gb_irq_prio_enc.sv
// Fixed-priority encoder for pending interrupts. Purely combinational.
// Ports:
//   pend  : NUM_IRQ pending-and-enabled flags, bit 0 = highest priority
//   idx   : index of the lowest set bit of pend (0 when none set)
//   valid : any bit of pend set
module gb_irq_prio_enc #(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] pend,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the lowest-priority bit upward so the last match, which is
  // the lowest index, is the one that sticks.
  always_comb begin
    idx   = '0;
    valid = |pend;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/gb_irq_ctrl.sv
// Game Boy interrupt controller: holds IF (FF0F) and IE (FFFF), picks the
// highest-priority pending and enabled source and presents a registered
// request plus dispatch vector to the CPU, which answers with int_ack.
//
// Build option: define GB_IRQ_EDGE_DETECT_EN to treat irq_in as levels
// (IF sets only on a 0->1 transition). Without it irq_in bits are pulses
// and every high cycle sets IF.
//
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   irq_in[NUM_IRQ]        : peripheral interrupt requests
//   cpu_sel_if/cpu_sel_ie  : CPU register selects
//   cpu_wr, cpu_di         : CPU write strobe and data
//   cpu_do                 : read data ({111, IF}, IE, or FF when unselected)
//   int_req, int_vector    : registered request and frozen dispatch address
//   int_ack                : one-cycle acknowledge from the CPU
//   wake                   : combinational any-pending-and-enabled for HALT exit
module gb_irq_ctrl
  import gb_pkg::*;
#(
  parameter int         NUM_IRQ       = 5,
  parameter logic [7:0] VECTOR_BASE   = VECTOR_BASE_DEF,
  parameter logic [7:0] VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cpu_sel_if,
  input  logic               cpu_sel_ie,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  output logic               int_req,
  output logic [7:0]         int_vector,
  input  logic               int_ack,
  output logic               wake
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_nx;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] irq_set;
  logic [IDX_W-1:0]   sel;
  logic               sel_vld;
  logic [IDX_W-1:0]   src_q;
  irq_state_e         state_q;

  // 8-bit vector arithmetic; wrap-around is acceptable.
  function automatic logic [7:0] calc_vector(input logic [IDX_W-1:0] idx);
    return VECTOR_BASE + (8'(idx) * VECTOR_STRIDE);
  endfunction

`ifdef GB_IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_d <= '0;
    else          irq_d <= irq_in;
  end

  assign irq_set = irq_in & ~irq_d;
`else
  assign irq_set = irq_in;
`endif

  assign pend = if_q & ie_q[NUM_IRQ-1:0];
  assign wake = |pend;

  gb_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .pend  (pend),
    .idx   (sel),
    .valid (sel_vld)
  );

  // IF update order: CPU write, then ack clear, then hardware sets, so a
  // peripheral pulse always survives a same-cycle clear.
  always_comb begin
    if_nx = if_q;
    if (cpu_sel_if && cpu_wr) if_nx = cpu_di[NUM_IRQ-1:0];
    if (state_q == PEND && int_ack) if_nx[src_q] = 1'b0;
    if_nx = if_nx | irq_set;
  end

  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_if)      cpu_do[NUM_IRQ-1:0] = if_q;
    else if (cpu_sel_ie) cpu_do = ie_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if_q <= if_nx;
      if (cpu_sel_ie && cpu_wr) ie_q <= cpu_di;
    end
  end

  // Dispatch FSM: the vector and source are latched on entry to PEND and
  // held until ack or withdrawal, regardless of later arrivals.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      int_req    <= 1'b0;
      int_vector <= VECTOR_BASE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            state_q    <= PEND;
            src_q      <= sel;
            int_vector <= calc_vector(sel);
            int_req    <= 1'b1;
          end
        end
        PEND: begin
          if (int_ack) begin
            state_q <= ACK;
            int_req <= 1'b0;
          end else if (!pend[src_q]) begin
            state_q <= IDLE;
            int_req <= 1'b0;
          end
        end
        ACK: begin
          state_q <= IDLE;
          int_req <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Directed bench for gb_irq_ctrl: a table of one-cycle stimulus records with
// hand-computed expectations, plus hand-written reset and level-hold sequences.
module tb_gb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] irq_in;
  logic       cpu_sel_if, cpu_sel_ie, cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       int_req;
  logic [7:0] int_vector;
  logic       int_ack;
  logic       wake;

  int checks = 0;
  int errors = 0;

  gb_irq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .cpu_sel_if (cpu_sel_if),
    .cpu_sel_ie (cpu_sel_ie),
    .cpu_wr     (cpu_wr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .int_req    (int_req),
    .int_vector (int_vector),
    .int_ack    (int_ack),
    .wake       (wake)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0] irq;
    logic       wr_if;
    logic       wr_ie;
    logic [7:0] di;
    logic       ack;
    logic [4:0] exp_if;
    logic       exp_req;
    logic [7:0] exp_vec;
    logic       exp_wake;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] irq, input logic wr_if, input logic wr_ie,
                     input logic [7:0] di, input logic ack, input logic [4:0] exp_if,
                     input logic exp_req, input logic [7:0] exp_vec, input logic exp_wake);
    vec_t v;
    v.irq = irq; v.wr_if = wr_if; v.wr_ie = wr_ie; v.di = di; v.ack = ack;
    v.exp_if = exp_if; v.exp_req = exp_req; v.exp_vec = exp_vec; v.exp_wake = exp_wake;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    irq_in = '0; cpu_sel_if = 0; cpu_sel_ie = 0; cpu_wr = 0; cpu_di = '0; int_ack = 0;
  endtask

  task automatic read_reg(input logic s_if, input logic s_ie, output logic [7:0] v);
    cpu_sel_if = s_if; cpu_sel_ie = s_ie; cpu_wr = 0;
    #1 v = cpu_do;
    cpu_sel_if = 0; cpu_sel_ie = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rd;

  initial begin
    idle_inputs();
    reset_n = 0;

    //            irq     wif wie di     ack exp_if   req vec    wake
    // Timer alone: 2-edge latency, ack, mandatory idle cycle
    add(5'h00, 0, 1, 8'h04, 0, 5'h00, 0, 8'h40, 0);
    add(5'h04, 0, 0, 8'h00, 0, 5'h04, 0, 8'h40, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 1, 5'h00, 0, 8'h50, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h00, 0, 8'h50, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h00, 0, 8'h50, 0);
    // Timer + joypad together: timer first, joypad after the ACK cycle
    add(5'h00, 0, 1, 8'h1F, 0, 5'h00, 0, 8'h50, 0);
    add(5'h14, 0, 0, 8'h00, 0, 5'h14, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h14, 1, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 1, 5'h10, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h10, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h10, 1, 8'h60, 1);
    // Vblank arriving in PEND does not move the frozen vector
    add(5'h01, 0, 0, 8'h00, 0, 5'h11, 1, 8'h60, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h11, 1, 8'h60, 1);
    add(5'h00, 0, 0, 8'h00, 1, 5'h01, 0, 8'h60, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h01, 0, 8'h60, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h01, 1, 8'h40, 1);
    add(5'h00, 0, 0, 8'h00, 1, 5'h00, 0, 8'h40, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h00, 0, 8'h40, 0);
    // CPU clears IF while pending: request withdrawn
    add(5'h04, 0, 0, 8'h00, 0, 5'h04, 0, 8'h40, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h00, 1, 0, 8'h00, 0, 5'h00, 1, 8'h50, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h00, 0, 8'h50, 0);
    // Same-cycle hardware set beats CPU clear, then beats ack clear
    add(5'h04, 0, 0, 8'h00, 0, 5'h04, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h04, 1, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h04, 0, 0, 8'h00, 1, 5'h04, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h04, 1, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 1, 5'h00, 0, 8'h50, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h00, 0, 8'h50, 0);
    // IE masked; ack in IDLE ignored; enabling IE wakes at once
    add(5'h00, 0, 1, 8'h00, 0, 5'h00, 0, 8'h50, 0);
    add(5'h02, 0, 0, 8'h00, 0, 5'h02, 0, 8'h50, 0);
    add(5'h00, 0, 0, 8'h00, 1, 5'h02, 0, 8'h50, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h02, 0, 8'h50, 0);
    add(5'h00, 0, 1, 8'h02, 0, 5'h02, 0, 8'h50, 1);
    add(5'h00, 0, 0, 8'h00, 0, 5'h02, 1, 8'h48, 1);
    add(5'h00, 0, 0, 8'h00, 1, 5'h00, 0, 8'h48, 0);
    add(5'h00, 0, 0, 8'h00, 0, 5'h00, 0, 8'h48, 0);

    // Reset state
    tick(); tick();
    chk("rst_req", {7'd0, int_req}, 8'h00);
    chk("rst_vec", int_vector, 8'h40);
    chk("rst_wake", {7'd0, wake}, 8'h00);
    chk("rst_do_none", cpu_do, 8'hFF);
    read_reg(1, 0, rd); chk("rst_if", rd, 8'hE0);
    read_reg(0, 1, rd); chk("rst_ie", rd, 8'h00);
    reset_n = 1;
    tick();

    // Table
    for (int i = 0; i < tbl.size(); i++) begin
      irq_in  = tbl[i].irq;
      int_ack = tbl[i].ack;
      cpu_di  = tbl[i].di;
      cpu_wr  = tbl[i].wr_if | tbl[i].wr_ie;
      cpu_sel_if = tbl[i].wr_if;
      cpu_sel_ie = tbl[i].wr_ie;
      tick();
      idle_inputs();
      chk($sformatf("row%0d_req", i), {7'd0, int_req}, {7'd0, tbl[i].exp_req});
      chk($sformatf("row%0d_vec", i), int_vector, tbl[i].exp_vec);
      chk($sformatf("row%0d_wake", i), {7'd0, wake}, {7'd0, tbl[i].exp_wake});
      read_reg(1, 0, rd);
      chk($sformatf("row%0d_if", i), rd, {3'b111, tbl[i].exp_if});
    end
    read_reg(0, 1, rd); chk("ie_readback", rd, 8'h02);

    // Asynchronous reset while in PEND; ack during reset is lost
    irq_in = 5'h02; tick(); irq_in = '0;
    tick();
    chk("pre_rst_req", {7'd0, int_req}, 8'h01);
    #2 reset_n = 0;
    #1;
    chk("async_req", {7'd0, int_req}, 8'h00);
    chk("async_vec", int_vector, 8'h40);
    chk("async_wake", {7'd0, wake}, 8'h00);
    read_reg(1, 0, rd); chk("async_if", rd, 8'hE0);
    read_reg(0, 1, rd); chk("async_ie", rd, 8'h00);
    int_ack = 1;
    tick();
    int_ack = 0;
    reset_n = 1;
    tick();
    chk("post_rst_req", {7'd0, int_req}, 8'h00);
    read_reg(1, 0, rd); chk("post_rst_if", rd, 8'hE0);

`ifdef GB_IRQ_EDGE_DETECT_EN
    // Level source held high sets IF once; a CPU clear is not undone
    irq_in = 5'h08;
    for (int c = 0; c < 10; c++) begin
      tick();
      read_reg(1, 0, rd); chk($sformatf("lvl_hold%0d_if", c), rd, 8'hE8);
    end
    cpu_sel_if = 1; cpu_wr = 1; cpu_di = 8'h00;
    tick();
    cpu_sel_if = 0; cpu_wr = 0;
    read_reg(1, 0, rd); chk("lvl_clr_if", rd, 8'hE0);
    for (int c = 0; c < 3; c++) begin
      tick();
      read_reg(1, 0, rd); chk($sformatf("lvl_after%0d_if", c), rd, 8'hE0);
    end
    irq_in = '0;
    tick();
`else
    // Pulse semantics: every high cycle sets IF, even against a CPU clear
    irq_in = 5'h08;
    for (int c = 0; c < 3; c++) begin
      tick();
      read_reg(1, 0, rd); chk($sformatf("pls_hold%0d_if", c), rd, 8'hE8);
    end
    cpu_sel_if = 1; cpu_wr = 1; cpu_di = 8'h00;
    tick();
    cpu_sel_if = 0; cpu_wr = 0;
    read_reg(1, 0, rd); chk("pls_clr_held_if", rd, 8'hE8);
    irq_in = '0;
    cpu_sel_if = 1; cpu_wr = 1; cpu_di = 8'h00;
    tick();
    cpu_sel_if = 0; cpu_wr = 0;
    read_reg(1, 0, rd); chk("pls_clr_if", rd, 8'hE0);
`endif
    chk("final_req", {7'd0, int_req}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
